// File: rtl/seg_scan_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_rx_pkg
// Description : Segment patterns, nibble codes and FSM encoding shared by the
//               7-segment scan receiver and its encoder counterpart.
// Revision    : 1.0
// ============================================================================
package seg_scan_rx_pkg;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1110011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hA;
    localparam logic [3:0] BCD_BAD   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seg_scan_rx_dec.sv
`default_nettype none
// ============================================================================
// Module      : seg_dec
// Description : Combinational 7-segment pattern to BCD nibble decoder.
// Revision    : 1.0
// ============================================================================
module seg_dec
    import seg_scan_rx_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_bad
);

    always_comb begin
        o_code = BCD_BAD;
        o_bad  = 1'b0;
        case (i_seg)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = BCD_BLANK;
            default:   o_bad  = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_rx.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_rx
// Description : Samples a multiplexed 7-segment scan bus, decodes each stable
//               digit and publishes complete six-digit frames plus mm:ss.
// Revision    : 1.0
// ============================================================================
module seg_scan_rx
    import seg_scan_rx_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int NUM_DIG    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             i_seg,
    input  logic                   i_seg_dp,
    input  logic [NUM_DIG-1:0]     i_seg_enb,
    output logic [4*NUM_DIG-1:0]   o_digits,
    output logic [NUM_DIG-1:0]     o_dp,
    output logic [5:0]             o_sec,
    output logic [5:0]             o_min,
    output logic                   o_time_vld,
    output logic                   o_frame_vld,
    output logic                   o_err
);

    localparam logic [7:0] c_CNT_LAST = 8'(STABLE_CYC - 1);

    logic [6:0]             r_seg_s1, r_seg_s2;
    logic                   r_dp_s1, r_dp_s2;
    logic [NUM_DIG-1:0]     r_enb_s1, r_enb_s2, r_enb_prev;

    state_t                 r_state, w_state_nx;
    logic [7:0]             r_cnt, w_cnt_nx;
    logic                   w_capture;

    logic [NUM_DIG-1:0]     w_enb_n;
    logic                   w_enb_vld, w_enb_chg;
    logic [3:0]             w_code;
    logic                   w_bad;

    logic [4*NUM_DIG-1:0]   r_stg_dig, w_stg_dig_nx;
    logic [NUM_DIG-1:0]     r_stg_dp, w_stg_dp_nx, r_seen, w_seen_nx;
    logic                   w_pub;
    logic [6:0]             w_sec7, w_min7;
    logic                   w_time_ok;

    logic [4*NUM_DIG-1:0]   r_digits;
    logic [NUM_DIG-1:0]     r_dp;
    logic [5:0]             r_sec, r_min;
    logic                   r_time_vld, r_frame_vld, r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_s1   <= '0;
            r_seg_s2   <= '0;
            r_dp_s1    <= 1'b0;
            r_dp_s2    <= 1'b0;
            r_enb_s1   <= '1;
            r_enb_s2   <= '1;
            r_enb_prev <= '1;
        end else begin
            r_seg_s1   <= i_seg;
            r_seg_s2   <= r_seg_s1;
            r_dp_s1    <= i_seg_dp;
            r_dp_s2    <= r_dp_s1;
            r_enb_s1   <= i_seg_enb;
            r_enb_s2   <= r_enb_s1;
            r_enb_prev <= r_enb_s2;
        end
    end

    // Valid enable: exactly one line pulled low.
    assign w_enb_n   = ~r_enb_s2;
    assign w_enb_vld = (w_enb_n != '0) && ((w_enb_n & (w_enb_n - NUM_DIG'(1))) == '0);
    assign w_enb_chg = (r_enb_s2 != r_enb_prev);

    seg_dec u_dec (
        .i_seg  (r_seg_s2),
        .o_code (w_code),
        .o_bad  (w_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_capture  = 1'b0;
        if (!w_enb_vld) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
        end else if (w_enb_chg) begin
            w_state_nx = ST_DWELL;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_DWELL;
                    w_cnt_nx   = '0;
                end
                ST_DWELL: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_capture  = 1'b1;
                        w_state_nx = ST_HOLD;
                    end else begin
                        w_cnt_nx = r_cnt + 8'd1;
                    end
                end
                default: w_state_nx = ST_HOLD;
            endcase
        end
    end

    // Staging image as it will look after this cycle's capture (if any).
    always_comb begin
        w_stg_dig_nx = r_stg_dig;
        w_stg_dp_nx  = r_stg_dp;
        w_seen_nx    = r_seen;
        if (w_capture) begin
            for (int k = 0; k < NUM_DIG; k++) begin
                if (w_enb_n[k]) begin
                    w_stg_dig_nx[4*k +: 4] = w_code;
                    w_stg_dp_nx[k]         = r_dp_s2;
                end
            end
            w_seen_nx = r_seen | w_enb_n;
        end
    end

    assign w_pub  = w_capture && (&w_seen_nx);
    assign w_sec7 = 7'(w_stg_dig_nx[7:4])   * 7'd10 + 7'(w_stg_dig_nx[3:0]);
    assign w_min7 = 7'(w_stg_dig_nx[15:12]) * 7'd10 + 7'(w_stg_dig_nx[11:8]);
    assign w_time_ok = (w_stg_dig_nx[3:0]   <= 4'd9) && (w_stg_dig_nx[7:4]   <= 4'd9) &&
                       (w_stg_dig_nx[11:8]  <= 4'd9) && (w_stg_dig_nx[15:12] <= 4'd9) &&
                       (w_sec7 <= 7'd59) && (w_min7 <= 7'd59);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_dig   <= '0;
            r_stg_dp    <= '0;
            r_seen      <= '0;
            r_digits    <= '0;
            r_dp        <= '0;
            r_sec       <= '0;
            r_min       <= '0;
            r_time_vld  <= 1'b0;
            r_frame_vld <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_stg_dig   <= w_stg_dig_nx;
            r_stg_dp    <= w_stg_dp_nx;
            r_seen      <= w_pub ? '0 : w_seen_nx;
            r_frame_vld <= w_pub;
            r_err       <= w_capture && w_bad;
            if (w_pub) begin
                r_digits   <= w_stg_dig_nx;
                r_dp       <= w_stg_dp_nx;
                r_time_vld <= w_time_ok;
                if (w_time_ok) begin
                    r_sec <= w_sec7[5:0];
                    r_min <= w_min7[5:0];
                end
            end
        end
    end

    assign o_digits    = r_digits;
    assign o_dp        = r_dp;
    assign o_sec       = r_sec;
    assign o_min       = r_min;
    assign o_time_vld  = r_time_vld;
    assign o_frame_vld = r_frame_vld;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: doc/seg_scan_rx.md
# seg_scan_rx

Receiving end of the multiplexed 7-segment scan bus driven by the display driver. It samples the active-low one-hot digit enable, segment and decimal-point lines, and decodes each stable digit back to BCD. After a full six-digit frame it publishes the digit values and the reconstructed minute/second values. It sits beside the display path as a self-check monitor and as a loop-back source for chained boards.

## Interface
- `STABLE_CYC`, 4: clk cycles an enable pattern must stay unchanged before its digit is captured; legal range 1..255.
- `NUM_DIG`, 6: digits per frame; fixed at 6 in this revision.
- `clk`  input  1  system clock, 50 MHz.
- `rst`  input  1  synchronous, active-high reset.
- `i_seg`  input  7  segments {a..g}, active-high.
- `i_seg_dp`  input  1  decimal point of the enabled digit.
- `i_seg_enb`  input  6  digit enable, active-low one-hot; bit k selects digit k.
- `o_digits`  output  24  six BCD nibbles, digit k at [4k+3:4k].
- `o_dp`  output  6  captured decimal points, bit k = digit k.
- `o_sec`  output  6  seconds, 0..59, from digit1*10 + digit0.
- `o_min`  output  6  minutes, 0..59, from digit3*10 + digit2.
- `o_time_vld`  output  1  level; o_sec/o_min are valid for the current frame.
- `o_frame_vld`  output  1  one-cycle pulse when a new frame is published.
- `o_err`  output  1  one-cycle pulse when an undecodable segment pattern is captured.

## Operation
- **Input sampling**
  - Two-stage register on i_seg, i_seg_dp and i_seg_enb.
  - All logic uses the second stage only.
- **Enable validity**
  - An enable is valid only if exactly one bit is 0.
  - All-ones or multiple zeros is invalid.
- **FSM states**
  - IDLE: enable invalid. Counter cleared; no capture.
  - DWELL: valid enable, counter running.
    - Counter `stab_cnt` is 8 bits and counts cycles with the enable unchanged.
    - When stab_cnt == STABLE_CYC-1, capture the digit and go to HOLD.
  - HOLD: digit already captured; wait.
- **FSM transitions**
  - Any enable change to another valid pattern goes to DWELL with stab_cnt = 0.
  - Any change to an invalid pattern goes to IDLE.
  - An enable that stays constant forever captures once only.
- **Segment decode** (inverse of the display encoder)
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1110011→9.
  - 0000000→4'hA (blank).
  - Any other pattern → 4'hF, with o_err pulsed in the capture cycle.
- **Capture**
  - Write the decoded nibble and dp into staging slot k.
  - Set bit k of the 6-bit `seen` mask.
  - Recapturing slot k before the frame completes overwrites the slot; the mask is unchanged.
- **Frame publish**
  - Condition: the capture cycle in which seen becomes 6'b111111.
  - Next cycle:
    - copy staging to o_digits/o_dp;
    - pulse o_frame_vld;
    - clear seen;
    - update o_sec/o_min/o_time_vld.
- **Time reconstruction**
  - Valid when digits 0..3 are all ≤9 and both results are ≤59.
  - In that case o_time_vld = 1 and o_sec/o_min are updated.
  - Otherwise o_time_vld = 0 and o_sec/o_min hold their previous values.
  - Arithmetic: tens*10 + ones in 7 bits, range-checked, then truncated to 6 bits.
- **Reset**
  - rst mid-frame discards the staging registers and the seen mask.
  - Reset values: o_digits=24'h0, o_dp=0, o_sec=0, o_min=0, o_time_vld=0, o_frame_vld=0, o_err=0, FSM=IDLE.

## Timing
- Input-to-logic latency: 2 cycles.
- Digit capture occurs STABLE_CYC cycles after the changed enable reaches stage 2. That is STABLE_CYC+2 cycles after the pin change.
- o_err is registered and asserted in the cycle after capture.
- o_frame_vld, o_digits, o_dp, o_sec, o_min and o_time_vld all update together, one cycle after the sixth distinct capture.
- Back-to-back frames: no dead cycle is needed; a capture in the publish cycle goes into the freshly cleared mask.
- With the driver's 10 kHz scan (100 µs per digit, 5000 cycles), any STABLE_CYC ≤ 255 captures every digit.

## Structure
- Shared package holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK (shared with the encoder);
  - nibble codes BCD_BLANK=4'hA and BCD_BAD=4'hF;
  - FSM state encoding IDLE/DWELL/HOLD.
- One sub-module: `seg_dec` — combinational 7-bit pattern → 4-bit code plus bad flag.
- Top: input register, FSM with stab_cnt, staging/seen, and the publish/arith stage.

## Test plan
- Scan digits 0..5 with patterns for "12:34" (d0=4, d1=3, d2=2, d3=1, d4/d5 blank), 5000 cycles each → one o_frame_vld pulse; o_digits=24'hAA1234, o_sec=34, o_min=12, o_time_vld=1, o_err=0.
- Enable held for STABLE_CYC-1 cycles then changed (glitch dwell) → no capture, seen unchanged, no frame pulse.
- Digit 0 driven with 1010101 → o_err pulses once; frame publishes with nibble 0=F; o_time_vld=0; o_sec/o_min keep the prior 34/12.
- Digit 1 pattern for 7 (d1*10+d0 = 70+) → frame publishes; o_time_vld=0.
- Enable 6'b111100 (two active), then 6'b111111 → FSM stays IDLE, no capture; the next valid scan resumes normally.
- Assert rst after 3 captures, then a full scan → outputs all zero during reset; the first frame after release contains only post-reset digits, with exactly one o_frame_vld pulse.
